timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer on the data bus, directly downstream of the CPU's M stage.
- Consumes the stage's store address, write data and write enable.
- Returns read data to the M-stage load path.
- Raises an interrupt request for the CPU's exception logic.
- Three word registers: CTRL, PRESET, COUNT. A 4-state FSM drives the count.

Parameters:
WIDTH, 32, width of PRESET, COUNT, wdata and rdata.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous reset, active-low: state clears at a posedge where reset==0
addr  input  2  word offset within device: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
we  input  1  write strobe, sampled at posedge
wdata  input  WIDTH  write data from the M stage
rdata  output  WIDTH  combinational read data for addr
irq  output  1  interrupt request to the CPU, level, registered

Behaviour:
- Reset (reset==0 at posedge):
  - CTRL=0, PRESET=0, COUNT=0, pend=0, state=IDLE.
  - irq=0 from the next cycle.
  - Reset mid-count aborts with no irq.
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), [3] IM (interrupt mask). Bits [WIDTH-1:4] read 0.
- Read (combinational, zero latency):
  - addr 0 gives {0, CTRL[3:0]}.
  - addr 1 gives PRESET.
  - addr 2 gives COUNT.
  - addr 3 gives 0.
- Write (we=1 at posedge):
  - addr 0 loads CTRL[3:0] from wdata[3:0].
  - addr 1 loads PRESET.
  - addr 2 and 3 are ignored; COUNT is read-only.
- FSM (evaluated with pre-edge register values):
  - IDLE: EN=1 goes to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT: EN=0 goes to IDLE (COUNT frozen). Else COUNT==0 goes to INT with pend<=1. Else COUNT<=COUNT-1.
  - INT, MODE 01: go to LOAD; pend<=0 at this edge, so pend is a 1-cycle pulse.
  - INT, other MODE: EN<=0, go to IDLE; pend holds until cleared.
- Latency: with PRESET=N, EN is written at edge t0 and pend=1 is visible after edge t0+N+3. INT state lasts one cycle.
- pend clearing:
  - one-shot: cleared by any CTRL write.
  - If a pend set and a CTRL write occur at the same edge, the set wins.
- irq = pend & IM, taken from registers with no combinational path from wdata.
- Simultaneous events:
  - A software CTRL write overrides the FSM's EN<=0 at the same edge.
  - Clearing EN during LOAD: LOAD still completes, then CNT sees EN=0 and goes to IDLE.
  - A PRESET write during CNT does not touch COUNT; it takes effect at the next LOAD.
  - PRESET=0: LOAD sets COUNT=0, the next CNT cycle enters INT.
- Arithmetic: unsigned; COUNT never decrements below 0 and never wraps.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, read all addrs. Required: rdata=0 for addr 0..3, irq=0, and no change over 20 idle cycles.
- One-shot: write PRESET=3, then CTRL=0x9 (EN=1, IM=1, MODE=00) at t0.
  - Required: COUNT reads 3,2,1,0 after edges t0+2..t0+5.
  - irq=1 after edge t0+6; CTRL reads 0x8 after edge t0+7.
  - irq stays 1 until a CTRL write of 0x8, then irq=0 after that edge.
- Auto-reload: PRESET=2, CTRL=0xB (MODE=01). Required: irq is a 1-cycle pulse every 5 cycles, and COUNT cycles 2,1,0 then holds 0 for the INT cycle.
- Mask and pause:
  - With PRESET=5 and CTRL=0x1 (IM=0), the count completes and irq stays 0; then writing CTRL=0x8 gives irq=0 because the CTRL write clears pend.
  - Separately, clearing EN mid-count with COUNT=4 freezes COUNT=4 and returns to IDLE.
  - Re-enabling reloads PRESET.
- Boundary writes:
  - PRESET=0 with EN set: irq after edge t0+3.
  - Writing COUNT (addr 2) with 0x55 leaves COUNT unchanged.
  - A PRESET write of 7 during CNT is applied only at the next LOAD.
- Reset mid-operation: with PRESET=10 running and COUNT=6, assert reset=0 for one edge. Required: all registers read 0, irq=0, and no interrupt afterwards.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers and a
// four-state count sequencer that raises a level interrupt on expiry.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for CTRL.EN; COUNT holds its last value
// ST_LOAD | copy PRESET into COUNT
// ST_CNT  | decrement COUNT each cycle; expire when COUNT is already 0
// ST_INT  | expiry cycle; auto-reload restarts, otherwise EN drops
module timer_dev #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t           state;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             pend;

    logic en;
    logic auto_reload;
    logic ctrl_wr;
    logic preset_wr;
    logic pend_set;
    logic reload_clr;

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign ctrl_wr     = we && (addr == ADDR_CTRL);
    assign preset_wr   = we && (addr == ADDR_PRESET);
    assign pend_set    = (state == ST_CNT) && en && (count == '0);
    assign reload_clr  = (state == ST_INT) && auto_reload;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        state <= ST_INT;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
                ST_INT: begin
                    state <= auto_reload ? ST_LOAD : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A software CTRL write beats the one-shot EN auto-clear.
            if (ctrl_wr) begin
                ctrl <= wdata[3:0];
            end else if ((state == ST_INT) && !auto_reload) begin
                ctrl[0] <= 1'b0;
            end

            if (preset_wr) preset <= wdata;

            // Expiry beats a same-edge CTRL write so no interrupt is lost.
            if (pend_set) begin
                pend <= 1'b1;
            end else if (ctrl_wr || reload_clr) begin
                pend <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata[3:0] = ctrl;
            ADDR_PRESET: rdata      = preset;
            ADDR_COUNT:  rdata      = count;
            default:     rdata      = '0;
        endcase
    end

    assign irq = pend & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: constant vector table, hand-written corner sequences
// and random bus traffic checked against a behavioural timer model.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_dev #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    // Behavioural model: the timer is described by what it is doing
    // (waiting, arming, counting down, firing) rather than by RTL states.
    string       m_activity;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;

    task automatic model_step(input logic rn, input logic w, input logic [1:0] a,
                              input logic [31:0] d);
        string       act;
        logic [3:0]  c;
        logic [31:0] n;
        logic        pd;
        logic        fired;
        if (!rn) begin
            m_activity = "waiting";
            m_ctrl = 4'h0; m_preset = 0; m_count = 0; m_pend = 1'b0;
            return;
        end
        act = m_activity; c = m_ctrl; n = m_count; pd = m_pend; fired = 1'b0;
        if (m_activity == "waiting") begin
            if (m_ctrl[0]) act = "arming";
        end else if (m_activity == "arming") begin
            n = m_preset;
            act = "counting";
        end else if (m_activity == "counting") begin
            if (!m_ctrl[0]) act = "waiting";
            else if (m_count == 0) begin act = "firing"; pd = 1'b1; fired = 1'b1; end
            else n = m_count - 1;
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin act = "arming"; pd = 1'b0; end
            else begin act = "waiting"; c[0] = 1'b0; end
        end
        if (w && a == 2'd0) begin
            c = d[3:0];
            if (!fired) pd = 1'b0;
        end
        if (w && a == 2'd1) m_preset = d;
        m_activity = act; m_ctrl = c; m_count = n; m_pend = pd;
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0: return {28'h0, m_ctrl};
            1: return m_preset;
            2: return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("%s model rd%0d", tag, a), rdata, model_read(a));
        end
        chk($sformatf("%s model irq", tag), {31'h0, irq}, {31'h0, m_pend & m_ctrl[3]});
    endtask

    // One clock edge with the given bus inputs, then a full model comparison.
    task automatic cycle(input logic rn, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input string tag);
        reset = rn; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_step(rn, w, a, d);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b1, 1'b0, 2'd0, 32'h0, tag);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    typedef struct {
        string       nm;
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_count;
        logic [3:0]  exp_ctrl;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] ec, input logic [3:0] ectl, input logic ei);
        vec_t v;
        v.nm = nm; v.w = w; v.a = a; v.d = d;
        v.exp_count = ec; v.exp_ctrl = ectl; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] ec, input logic [3:0] ectl,
                            input logic ei);
        logic [31:0] v;
        rd(2'd2, v); chk({nm, " count"}, v, ec);
        rd(2'd0, v); chk({nm, " ctrl"}, v, {28'h0, ectl});
        chk({nm, " irq"}, {31'h0, irq}, {31'h0, ei});
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;

        // Reset for two edges, then twenty quiet cycles.
        cycle(1'b0, 1'b0, 2'd0, 32'h0, "rst0");
        cycle(1'b0, 1'b0, 2'd0, 32'h0, "rst1");
        for (int i = 0; i < 20; i++) begin
            idle($sformatf("idle%0d", i));
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), v);
                chk($sformatf("idle%0d rd%0d", i, a), v, 32'h0);
            end
            chk($sformatf("idle%0d irq", i), {31'h0, irq}, 32'h0);
        end

        // One-shot PRESET=3, COUNT write ignored, PRESET=0 boundary.
        add("preset3",  1, 2'd1, 32'd3,  0, 4'h0, 0);
        add("os_en",    1, 2'd0, 32'h9,  0, 4'h9, 0);
        add("os_load",  0, 2'd0, 32'h0,  0, 4'h9, 0);
        add("os_c3",    0, 2'd0, 32'h0,  3, 4'h9, 0);
        add("os_c2",    0, 2'd0, 32'h0,  2, 4'h9, 0);
        add("os_c1",    0, 2'd0, 32'h0,  1, 4'h9, 0);
        add("os_c0",    0, 2'd0, 32'h0,  0, 4'h9, 0);
        add("os_int",   0, 2'd0, 32'h0,  0, 4'h9, 1);
        add("os_encl",  0, 2'd0, 32'h0,  0, 4'h8, 1);
        add("os_hold",  0, 2'd0, 32'h0,  0, 4'h8, 1);
        add("os_clr",   1, 2'd0, 32'h8,  0, 4'h8, 0);
        add("os_quiet", 0, 2'd0, 32'h0,  0, 4'h8, 0);
        add("wr_count", 1, 2'd2, 32'h55, 0, 4'h8, 0);
        add("wr_rsvd",  1, 2'd3, 32'hff, 0, 4'h8, 0);
        add("preset0",  1, 2'd1, 32'd0,  0, 4'h8, 0);
        add("z_en",     1, 2'd0, 32'h9,  0, 4'h9, 0);
        add("z_load",   0, 2'd0, 32'h0,  0, 4'h9, 0);
        add("z_cnt",    0, 2'd0, 32'h0,  0, 4'h9, 0);
        add("z_int",    0, 2'd0, 32'h0,  0, 4'h9, 1);
        add("z_idle",   0, 2'd0, 32'h0,  0, 4'h8, 1);
        add("z_clr",    1, 2'd0, 32'h0,  0, 4'h0, 0);
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].nm);
            chk_regs(vecs[i].nm, vecs[i].exp_count, vecs[i].exp_ctrl, vecs[i].exp_irq);
        end
        rd(2'd1, v); chk("preset_after_table", v, 32'd0);

        // Expiry and CTRL write on the same edge; then a CTRL write during
        // the expiry cycle keeps EN and clears the pending interrupt.
        cycle(1'b1, 1'b1, 2'd0, 32'h9, "sw_en");
        idle("sw_load");
        idle("sw_cnt");
        cycle(1'b1, 1'b1, 2'd0, 32'h9, "sw_setwins");
        chk_regs("sw_setwins", 0, 4'h9, 1);
        cycle(1'b1, 1'b1, 2'd0, 32'h9, "sw_override");
        chk_regs("sw_override", 0, 4'h9, 0);
        cycle(1'b1, 1'b1, 2'd0, 32'h0, "sw_stop");
        for (int i = 0; i < 4; i++) idle("sw_drain");

        // Auto-reload PRESET=2: one-cycle pulse every five cycles.
        cycle(1'b1, 1'b1, 2'd1, 32'd2, "ar_preset");
        cycle(1'b1, 1'b1, 2'd0, 32'hB, "ar_en");
        for (int k = 1; k <= 16; k++) begin
            int pat[5] = '{2, 1, 0, 0, 0};
            idle($sformatf("ar%0d", k));
            chk($sformatf("ar%0d irq", k), {31'h0, irq},
                {31'h0, (k >= 5 && (k - 5) % 5 == 0) ? 1'b1 : 1'b0});
            if (k >= 2) begin
                rd(2'd2, v);
                chk($sformatf("ar%0d count", k), v, 32'(pat[(k - 2) % 5]));
            end
        end
        cycle(1'b1, 1'b1, 2'd0, 32'h0, "ar_stop");
        for (int i = 0; i < 4; i++) idle("ar_drain");

        // Masked expiry: pend sets but irq stays low; a CTRL write clears it.
        cycle(1'b1, 1'b1, 2'd1, 32'd5, "mk_preset");
        cycle(1'b1, 1'b1, 2'd0, 32'h1, "mk_en");
        for (int i = 0; i < 10; i++) begin
            idle("mk_run");
            chk($sformatf("mk_run%0d irq", i), {31'h0, irq}, 32'h0);
        end
        chk_regs("mk_done", 0, 4'h0, 0);
        cycle(1'b1, 1'b1, 2'd0, 32'h8, "mk_unmask");
        chk_regs("mk_unmask", 0, 4'h8, 0);
        idle("mk_after");
        chk_regs("mk_after", 0, 4'h8, 0);

        // Pause at COUNT=4, then re-enable reloads PRESET.
        cycle(1'b1, 1'b1, 2'd0, 32'h1, "pz_en");
        idle("pz_load");
        idle("pz_c5");
        cycle(1'b1, 1'b1, 2'd0, 32'h0, "pz_off");
        for (int i = 0; i < 4; i++) begin
            idle("pz_frozen");
            chk_regs($sformatf("pz_frozen%0d", i), 4, 4'h0, 0);
        end
        cycle(1'b1, 1'b1, 2'd0, 32'h1, "pz_reen");
        idle("pz_reload");
        idle("pz_c5b");
        chk_regs("pz_c5b", 5, 4'h1, 0);

        // PRESET write mid-count only affects the next load.
        cycle(1'b1, 1'b1, 2'd1, 32'd7, "pw_write");
        chk_regs("pw_write", 4, 4'h1, 0);
        for (int i = 0; i < 8; i++) idle("pw_run");
        chk_regs("pw_done", 0, 4'h0, 0);
        cycle(1'b1, 1'b1, 2'd0, 32'h1, "pw_en");
        idle("pw_load");
        idle("pw_c7");
        chk_regs("pw_c7", 7, 4'h1, 0);
        cycle(1'b1, 1'b1, 2'd0, 32'h0, "pw_stop");

        // Reset in the middle of a PRESET=10 count.
        cycle(1'b1, 1'b1, 2'd1, 32'd10, "rm_preset");
        cycle(1'b1, 1'b1, 2'd0, 32'h9, "rm_en");
        for (int i = 0; i < 6; i++) idle("rm_run");
        chk_regs("rm_c6", 6, 4'h9, 0);
        cycle(1'b0, 1'b0, 2'd0, 32'h0, "rm_reset");
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk($sformatf("rm_reset rd%0d", a), v, 32'h0);
        end
        chk("rm_reset irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            idle("rm_after");
            chk($sformatf("rm_after%0d irq", i), {31'h0, irq}, 32'h0);
        end

        // Random bus traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        rn;
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            rn = ($urandom_range(0, 79) != 0);
            w  = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            cycle(rn, w, a, d, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
